// File: rtl/arith_encoder_param.sv
// Integer arithmetic encoder with a run-time loadable cumulative-count table.
// Symbols enter on a valid/ready handshake; coded bits leave on a back-pressured serial port.
module arith_encoder_param #(
   parameter int PREC      = 10,
   parameter int NSYM      = 6,
   parameter int SYM_W     = 3,
   parameter int CNT_W     = 8,
   parameter int TOTAL     = 96,
   parameter int FRAME_LEN = 96,
   parameter int PEND_W    = 7
) (
   input  logic             sys_clk,
   input  logic             sys_reset,
   input  logic [SYM_W-1:0] sym_in,
   input  logic             sym_valid,
   output logic             sym_ready,
   input  logic             cum_wr_en,
   input  logic [SYM_W-1:0] cum_wr_addr,
   input  logic [CNT_W-1:0] cum_wr_data,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             frame_done,
   output logic             sym_err,
   output logic             pend_ovf
);
   localparam int CW = $clog2(FRAME_LEN + 1);
   localparam int FW = $clog2(PREC);
   localparam int PW = PREC + CNT_W + 1;

   typedef enum logic [2:0] {IDLE, UPDATE, RENORM, EMIT_PEND, FLUSH, DONE} state_e;

   state_e            state_q, state_d;
   logic [PREC-1:0]   low_q, low_d, high_q, high_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;
   logic [SYM_W-1:0]  idx_q, idx_d;
   logic              b_q, b_d, err_q, err_d, ovf_q, ovf_d;
   logic [CNT_W-1:0]  cum_q [1:NSYM-1];
   logic [CNT_W-1:0]  cum_full [0:NSYM];
   logic [CNT_W-1:0]  c_lo, c_hi;
   logic [SYM_W-1:0]  sel;
   logic              in_rng, sym_ok;
   logic [PREC:0]     rng;
   logic [PW-1:0]     q_lo, q_hi;
   logic [FW-1:0]     fl_idx;

   // Table view with the fixed end points folded in
   always_comb begin
      cum_full[0]    = '0;
      cum_full[NSYM] = CNT_W'(TOTAL);
      for (int k = 1; k < NSYM; k++) cum_full[k] = cum_q[k];
   end

   assign sel = (state_q == IDLE) ? sym_in : idx_q;

   always_comb begin
      c_lo   = '0;
      c_hi   = '0;
      in_rng = 1'b0;
      for (int k = 0; k < NSYM; k++) begin
         if (sel == SYM_W'(k)) begin
            c_lo   = cum_full[k];
            c_hi   = cum_full[k+1];
            in_rng = 1'b1;
         end
      end
   end

   assign sym_ok = in_rng && (c_hi > c_lo);
   assign rng    = {1'b0, high_q} - {1'b0, low_q} + (PREC+1)'(1);
   assign q_lo   = (PW'(rng) * PW'(c_lo)) / PW'(TOTAL);
   assign q_hi   = (PW'(rng) * PW'(c_hi)) / PW'(TOTAL);
   assign fl_idx = FW'(PREC - 1) - fcnt_q;

   always_comb begin
      state_d    = state_q;
      low_d      = low_q;
      high_d     = high_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      fcnt_d     = fcnt_q;
      idx_d      = idx_q;
      b_d        = b_q;
      err_d      = 1'b0;
      ovf_d      = ovf_q;
      sym_ready  = 1'b0;
      bit_valid  = 1'b0;
      bit_out    = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            sym_ready = 1'b1;
            if (sym_valid) begin
               if (sym_ok) begin
                  idx_d   = sym_in;
                  state_d = UPDATE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         UPDATE: begin
            low_d   = PREC'(PW'(low_q) + q_lo);
            high_d  = PREC'(PW'(low_q) + q_hi - PW'(1));
            state_d = RENORM;
         end
         RENORM: begin
            if (low_q[PREC-1] == high_q[PREC-1]) begin
               bit_valid = 1'b1;
               bit_out   = low_q[PREC-1];
               if (bit_ready) begin
                  b_d    = low_q[PREC-1];
                  low_d  = {low_q[PREC-2:0], 1'b0};
                  high_d = {high_q[PREC-2:0], 1'b1};
                  if (pend_q != '0) state_d = EMIT_PEND;
               end
            end else if (low_q[PREC-2] && !high_q[PREC-2]) begin
               // Straddling the midpoint: shift and flip the second MSB
               low_d  = {1'b0, low_q[PREC-3:0], 1'b0};
               high_d = {1'b1, high_q[PREC-3:0], 1'b1};
               if (&pend_q) ovf_d  = 1'b1;
               else         pend_d = pend_q + PEND_W'(1);
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = (cnt_q == CW'(FRAME_LEN - 1)) ? FLUSH : IDLE;
            end
         end
         EMIT_PEND: begin
            bit_valid = 1'b1;
            bit_out   = ~b_q;
            if (bit_ready) begin
               pend_d = pend_q - PEND_W'(1);
               if (pend_q == PEND_W'(1)) state_d = RENORM;
            end
         end
         FLUSH: begin
            bit_valid = 1'b1;
            if (fcnt_q == '0)        bit_out = low_q[PREC-1];
            else if (pend_q != '0)   bit_out = ~b_q;
            else                     bit_out = low_q[fl_idx];
            if (bit_ready) begin
               if (fcnt_q == '0) begin
                  b_d    = low_q[PREC-1];
                  fcnt_d = FW'(1);
               end else if (pend_q != '0) begin
                  pend_d = pend_q - PEND_W'(1);
               end else if (fcnt_q == FW'(PREC - 1)) begin
                  state_d = DONE;
               end else begin
                  fcnt_d = fcnt_q + FW'(1);
               end
            end
         end
         DONE: begin
            frame_done = 1'b1;
            low_d      = '0;
            high_d     = '1;
            pend_d     = '0;
            cnt_d      = '0;
            fcnt_d     = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         state_q <= IDLE;
         low_q   <= '0;
         high_q  <= '1;
         pend_q  <= '0;
         cnt_q   <= '0;
         fcnt_q  <= '0;
         idx_q   <= '0;
         b_q     <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         low_q   <= low_d;
         high_q  <= high_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         idx_q   <= idx_d;
         b_q     <= b_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_reset) begin
      if (!sys_reset) begin
         for (int k = 1; k < NSYM; k++) cum_q[k] <= '0;
      end else if (cum_wr_en && state_q == IDLE) begin
         for (int k = 1; k < NSYM; k++)
            if (cum_wr_addr == SYM_W'(k)) cum_q[k] <= cum_wr_data;
      end
   end

   assign sym_err  = err_q;
   assign pend_ovf = ovf_q;

endmodule

// File: tb/tb_arith_encoder_param.sv
// Directed bench for arith_encoder_param: single-symbol vector table, handshake and
// table-write sequences, a modelled random frame, and a short-frame pending-overflow case.
module tb_arith_encoder_param;
   logic       sys_clk, sys_reset;
   logic [2:0] sym_in;
   logic       sym_valid, s_sym_valid;
   logic       cum_wr_en;
   logic [2:0] cum_wr_addr;
   logic [7:0] cum_wr_data;
   logic       bit_ready;
   logic       sym_ready, bit_out, bit_valid, frame_done, sym_err, pend_ovf;
   logic       s_sym_ready, s_bit_out, s_bit_valid, s_frame_done, s_sym_err, s_pend_ovf;

   arith_encoder_param dut (
      .sys_clk(sys_clk), .sys_reset(sys_reset), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .cum_wr_en(cum_wr_en), .cum_wr_addr(cum_wr_addr),
      .cum_wr_data(cum_wr_data), .bit_out(bit_out), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .frame_done(frame_done), .sym_err(sym_err), .pend_ovf(pend_ovf));

   arith_encoder_param #(.FRAME_LEN(2), .PEND_W(2)) u_small (
      .sys_clk(sys_clk), .sys_reset(sys_reset), .sym_in(sym_in), .sym_valid(s_sym_valid),
      .sym_ready(s_sym_ready), .cum_wr_en(cum_wr_en), .cum_wr_addr(cum_wr_addr),
      .cum_wr_data(cum_wr_data), .bit_out(s_bit_out), .bit_valid(s_bit_valid),
      .bit_ready(bit_ready), .frame_done(s_frame_done), .sym_err(s_sym_err), .pend_ovf(s_pend_ovf));

   typedef struct {int sym; int c3; int low; int high; int nbits; int bits; int err;} vec_t;
   vec_t vt [9];

   int n_chk = 0, n_pass = 0;
   int rdy_mode = 1;
   int done_cnt = 0, err_cnt = 0;
   bit got[$], s_got[$], exp_q[$];
   int frame [96];
   int cm [0:6] = '{0, 2, 71, 90, 94, 96, 96};

   initial begin
      sys_clk = 0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      bit_ready = 0;
      forever begin
         @(posedge sys_clk); #2;
         case (rdy_mode)
            0:       bit_ready = 1'b0;
            1:       bit_ready = 1'b1;
            default: bit_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge sys_clk) begin
      if (bit_valid && bit_ready) got.push_back(bit_out);
      if (s_bit_valid && bit_ready) s_got.push_back(s_bit_out);
      if (frame_done) done_cnt++;
      if (sym_err) err_cnt++;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic do_reset();
      sys_reset = 0; cum_wr_en = 0; sym_valid = 0; s_sym_valid = 0;
      repeat (2) @(negedge sys_clk);
      sys_reset = 1;
      @(negedge sys_clk);
      got.delete(); s_got.delete();
   endtask

   task automatic wr(input int a, input int d);
      cum_wr_en = 1; cum_wr_addr = 3'(a); cum_wr_data = 8'(d);
      @(negedge sys_clk);
      cum_wr_en = 0;
   endtask

   task automatic load_main(input int c3);
      wr(1, 2); wr(2, 71); wr(3, c3); wr(4, 94); wr(5, 96);
   endtask

   task automatic wait_rdy(input bit sel, input string nm);
      int n = 0;
      while (!(sel ? s_sym_ready : sym_ready) && n < 3000) begin
         @(negedge sys_clk); n++;
      end
      if (n >= 3000) begin
         n_chk++;
         $display("FAIL %s: sym_ready never returned within %0d cycles", nm, n);
      end
   endtask

   task automatic send(input int s, input bit sel);
      wait_rdy(sel, "send_wait");
      sym_in = 3'(s);
      if (sel) s_sym_valid = 1; else sym_valid = 1;
      @(negedge sys_clk);
      sym_valid = 0; s_sym_valid = 0;
   endtask

   task automatic build_model();
      int lo, hi, pd, r, b;
      bit go;
      lo = 0; hi = 1023; pd = 0;
      exp_q.delete();
      for (int i = 0; i < 96; i++) begin
         r  = hi - lo + 1;
         hi = lo + (r * cm[frame[i]+1]) / 96 - 1;
         lo = lo + (r * cm[frame[i]]) / 96;
         go = 1;
         while (go) begin
            if (((lo >> 9) & 1) == ((hi >> 9) & 1)) begin
               b = (lo >> 9) & 1;
               exp_q.push_back(b[0]);
               lo = (lo << 1) & 1023; hi = ((hi << 1) | 1) & 1023;
               repeat (pd) exp_q.push_back(~b[0]);
               pd = 0;
            end else if (((lo >> 8) & 1) == 1 && ((hi >> 8) & 1) == 0) begin
               lo = ((lo << 1) & 1023) ^ 512; hi = (((hi << 1) | 1) & 1023) ^ 512;
               if (pd < 127) pd++;
            end else go = 0;
         end
      end
      b = (lo >> 9) & 1;
      exp_q.push_back(b[0]);
      repeat (pd) exp_q.push_back(~b[0]);
      for (int k = 8; k >= 0; k--) begin
         b = (lo >> k) & 1;
         exp_q.push_back(b[0]);
      end
   endtask

   initial begin
      int e0, d0, w, mism, n;
      bit stable;
      logic [2:0] rs;

      vt[0] = '{1, 90,  21,  756, 0, 0,    0};
      vt[1] = '{0, 90,   0,  671, 5, 0,    0};
      vt[2] = '{2, 90, 490,  895, 1, 1,    0};
      vt[3] = '{3, 90,   0,  671, 4, 'hF,  0};
      vt[4] = '{4, 90, 320, 1023, 5, 'h1F, 0};
      vt[5] = '{5, 90,   0, 1023, 0, 0,    1};
      vt[6] = '{6, 90,   0, 1023, 0, 0,    1};
      vt[7] = '{7, 90,   0, 1023, 0, 0,    1};
      vt[8] = '{2, 80, 468,  851, 1, 1,    0};

      sys_reset = 0; sym_in = 0; sym_valid = 0; s_sym_valid = 0;
      cum_wr_en = 0; cum_wr_addr = 0; cum_wr_data = 0;
      repeat (2) @(negedge sys_clk);
      chk("rst_sym_ready", sym_ready, 1);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_bit_out", bit_out, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_sym_err", sym_err, 0);
      chk("rst_pend_ovf", pend_ovf, 0);
      chk("rst_low", dut.low_q, 0);
      chk("rst_high", dut.high_q, 1023);

      // Single symbols from the reset coder state
      rdy_mode = 1;
      for (int i = 0; i < 9; i++) begin
         do_reset();
         load_main(vt[i].c3);
         e0 = err_cnt;
         send(vt[i].sym, 0);
         wait_rdy(0, $sformatf("vec%0d_idle", i));
         repeat (2) @(negedge sys_clk);
         w = 0;
         foreach (got[k]) w = (w << 1) | int'(got[k]);
         chk($sformatf("vec%0d_nbits", i), got.size(), vt[i].nbits);
         chk($sformatf("vec%0d_bits", i), w, vt[i].bits);
         chk($sformatf("vec%0d_low", i), dut.low_q, vt[i].low);
         chk($sformatf("vec%0d_high", i), dut.high_q, vt[i].high);
         chk($sformatf("vec%0d_err", i), err_cnt - e0, vt[i].err);
      end

      // Latency of a bit-less symbol: ready again on the third cycle after acceptance
      do_reset(); load_main(90);
      send(1, 0);
      stable = 1;
      for (int k = 0; k < 3; k++) begin
         rs[2-k] = sym_ready;
         if (bit_valid) stable = 0;
         if (k < 2) @(negedge sys_clk);
      end
      chk("lat_ready_seq", rs, 3'b001);
      chk("lat_no_bits", stable, 1);

      // Back-pressure on the idx0 stream
      do_reset(); load_main(90);
      rdy_mode = 0;
      send(0, 0);
      n = 0;
      while (!bit_valid && n < 20) begin @(negedge sys_clk); n++; end
      chk("hold_valid_seen", bit_valid, 1);
      stable = 1;
      repeat (10) begin
         if (!(bit_valid && bit_out == 0 && !sym_ready && dut.low_q == 0 && dut.high_q == 20))
            stable = 0;
         @(negedge sys_clk);
      end
      chk("hold_stable", stable, 1);
      chk("hold_no_bits", got.size(), 0);
      rdy_mode = 1;
      wait_rdy(0, "hold_release");
      w = 0;
      foreach (got[k]) w = (w << 1) | int'(got[k]);
      chk("hold_nbits", got.size(), 5);
      chk("hold_bits", w, 0);
      chk("hold_high", dut.high_q, 671);

      // Table write during RENORM is ignored; illegal symbol leaves coder untouched
      do_reset(); load_main(90);
      rdy_mode = 0;
      send(2, 0);
      n = 0;
      while (!bit_valid && n < 20) begin @(negedge sys_clk); n++; end
      wr(3, 80);
      chk("busy_write_ignored", dut.cum_q[3], 90);
      rdy_mode = 1;
      wait_rdy(0, "busy_release");
      e0 = err_cnt;
      send(6, 0);
      repeat (2) @(negedge sys_clk);
      chk("ill_err_pulse", err_cnt - e0, 1);
      chk("ill_low", dut.low_q, 490);
      chk("ill_high", dut.high_q, 895);
      chk("ill_ready", sym_ready, 1);
      wr(3, 80);
      chk("idle_write_taken", dut.cum_q[3], 80);

      // Full random frame against the model, random back-pressure
      do_reset(); load_main(90);
      for (int i = 0; i < 96; i++) frame[i] = $urandom_range(0, 4);
      build_model();
      rdy_mode = 2;
      d0 = done_cnt;
      for (int i = 0; i < 96; i++) send(frame[i], 0);
      n = 0;
      while (done_cnt == d0 && n < 3000) begin @(negedge sys_clk); n++; end
      repeat (3) @(negedge sys_clk);
      rdy_mode = 1;
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         if (got[i] != exp_q[i]) mism++;
      chk("frame_len", got.size(), exp_q.size());
      chk("frame_bit_mismatches", mism, 0);
      chk("frame_done_pulses", done_cnt - d0, 1);
      chk("frame_low_cleared", dut.low_q, 0);
      chk("frame_high_cleared", dut.high_q, 1023);
      chk("frame_ready", sym_ready, 1);

      // Short frame: four E3 hits overflow a 2-bit pending counter, then reset mid-FLUSH
      do_reset();
      wr(1, 47); wr(2, 50);
      send(1, 1);
      wait_rdy(1, "small_sym1");
      chk("small_ovf_set", s_pend_ovf, 1);
      chk("small_no_bits", s_got.size(), 0);
      chk("small_pend_sat", u_small.pend_q, 3);
      send(1, 1);
      n = 0;
      while (s_got.size() < 12 && n < 200) begin @(negedge sys_clk); n++; end
      w = 0;
      for (int k = 0; k < 12 && k < s_got.size(); k++) w = (w << 1) | int'(s_got[k]);
      chk("small_stream12", w, 'h825);
      chk("small_ovf_sticky", s_pend_ovf, 1);
      chk("small_in_flush_valid", s_bit_valid, 1);
      sys_reset = 0;
      #1;
      chk("mid_rst_valid", s_bit_valid, 0);
      chk("mid_rst_bit_out", s_bit_out, 0);
      chk("mid_rst_ready", s_sym_ready, 1);
      chk("mid_rst_ovf", s_pend_ovf, 0);
      @(posedge sys_clk); #1;
      chk("mid_rst_done", s_frame_done, 0);
      chk("mid_rst_err", s_sym_err, 0);
      chk("mid_rst_low", u_small.low_q, 0);
      chk("mid_rst_high", u_small.high_q, 1023);
      @(negedge sys_clk);
      sys_reset = 1;
      repeat (2) @(negedge sys_clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
